// File: rtl/vdp_pixel_pkg.sv
// Shared pixel/word types and the span-builder state encoding for the draw pipeline.
package vdp_pixel_pkg;

  localparam int PIXEL_W      = 9;
  localparam int PIX_PER_WORD = 8;

  typedef logic [PIX_PER_WORD*PIXEL_W-1:0]   pixel_word_t;
  typedef logic [2*PIX_PER_WORD*PIXEL_W-1:0] pixel_window_t;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    RUN
  } state_t;

endpackage

// File: rtl/span_window_builder_mask.sv
// Span mask for one 16-pixel window: bit j set iff p+j lies in [0, width).
module span_mask_gen
  import vdp_pixel_pkg::*;
#(
  parameter int X_W = 11
) (
  input  logic signed [X_W+1:0]          p,
  input  logic        [X_W-1:0]          width,
  output logic        [2*PIX_PER_WORD-1:0] mask
);

  for (genvar gi = 0; gi < 2*PIX_PER_WORD; gi++) begin : g_bit
    logic [X_W+2:0] pos;
    // One extra bit so a negative p never wraps into the valid range.
    assign pos = {p[X_W+1], p} + (X_W+3)'(gi);
    assign mask[gi] = !pos[X_W+2] && (pos[X_W+1:0] < {2'b00, width});
  end

endmodule

// File: rtl/span_window_builder.sv
// Builds 16-pixel {hi, lo} source windows per destination word for the shift aligner.
module span_window_builder #(
  parameter int PIXEL_W = vdp_pixel_pkg::PIXEL_W,
  parameter int X_W     = 11
) (
  input  logic                   clk_draw,
  input  logic                   rst_draw_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [X_W-1:0]         cmd_src_x,
  input  logic [X_W-1:0]         cmd_dst_x,
  input  logic [X_W-1:0]         cmd_width,
  input  logic                   src_valid,
  output logic                   src_ready,
  input  logic [8*PIXEL_W-1:0]   src_pixels,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [16*PIXEL_W-1:0]  unaligned_pixels,
  output logic [15:0]            unaligned_valid_mask,
  output logic [2:0]             alignment_shift,
  output logic                   out_last
);
  import vdp_pixel_pkg::*;

  localparam int CW     = X_W + 1;
  localparam int PW     = X_W + 2;
  localparam int WORD_W = $bits(pixel_word_t);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  state_t                 state_reg;
  logic                   prime_hi_reg;
  logic signed [PW-1:0]   p_reg;
  logic [X_W-1:0]         width_reg;
  logic [CW-1:0]          words_left_reg;
  logic [CW-1:0]          beats_left_reg;
  pixel_window_t          pix_reg;
  logic [15:0]            mask_reg;
  logic [2:0]             shift_reg;
  logic                   out_valid_reg;
  logic                   last_reg;

  logic [CW-1:0]          sa_w, da_w, src_words_w, beats_w;
  logic                   phantom_w;
  logic signed [PW-1:0]   p0_w, mask_p_w;
  logic [15:0]            mask_next;
  logic                   need_word, do_adv, take;
  pixel_word_t            word_in;

  always_comb begin
    sa_w        = CW'(cmd_src_x[2:0]);
    da_w        = CW'(cmd_dst_x[2:0]);
    phantom_w   = cmd_src_x[2:0] < cmd_dst_x[2:0];
    src_words_w = (CW'(cmd_width) + sa_w + CW'(7)) >> 3;
    beats_w     = (CW'(cmd_width) + da_w + CW'(7)) >> 3;
    p0_w        = phantom_w ? -(PW'(sa_w) + PW'(8)) : -PW'(sa_w);
  end

  // Once the source quota is spent, further words are synthesised as zeros.
  assign need_word = words_left_reg != '0;
  assign word_in   = need_word ? src_pixels : '0;
  // In RUN an empty output register means an advance is still waiting on a source word.
  assign do_adv    = (state_reg == RUN) && (out_valid_reg ? (out_ready && !last_reg) : 1'b1);
  assign src_ready = need_word && ((state_reg == PRIME) || do_adv);
  assign take      = !need_word || src_valid;
  assign mask_p_w  = (state_reg == RUN) ? p_reg + PW'(8) : p_reg;

  span_mask_gen #(.X_W(X_W)) u_mask (
    .p     (mask_p_w),
    .width (width_reg),
    .mask  (mask_next)
  );

  always_ff @(posedge clk_draw) begin
    if (!rst_draw_n) begin
      state_reg      <= IDLE;
      prime_hi_reg   <= 1'b0;
      p_reg          <= '0;
      width_reg      <= '0;
      words_left_reg <= '0;
      beats_left_reg <= '0;
      pix_reg        <= '0;
      mask_reg       <= '0;
      shift_reg      <= '0;
      out_valid_reg  <= 1'b0;
      last_reg       <= 1'b0;
    end else begin
      if (src_ready && src_valid) begin
        words_left_reg <= words_left_reg - ONE_C;
      end
      case (state_reg)
        IDLE: begin
          if (cmd_valid && cmd_width != '0) begin
            state_reg      <= PRIME;
            prime_hi_reg   <= phantom_w;
            p_reg          <= p0_w;
            width_reg      <= cmd_width;
            words_left_reg <= src_words_w;
            beats_left_reg <= beats_w;
            shift_reg      <= cmd_src_x[2:0] - cmd_dst_x[2:0];
            pix_reg        <= '0;
          end
        end
        PRIME: begin
          if (take) begin
            if (!prime_hi_reg) begin
              pix_reg[WORD_W-1:0] <= word_in;
              prime_hi_reg        <= 1'b1;
            end else begin
              pix_reg[2*WORD_W-1:WORD_W] <= word_in;
              mask_reg       <= mask_next;
              last_reg       <= beats_left_reg == ONE_C;
              beats_left_reg <= beats_left_reg - ONE_C;
              out_valid_reg  <= 1'b1;
              state_reg      <= RUN;
            end
          end
        end
        RUN: begin
          if (out_valid_reg && out_ready && last_reg) begin
            out_valid_reg <= 1'b0;
            last_reg      <= 1'b0;
            state_reg     <= IDLE;
          end else if (do_adv) begin
            if (take) begin
              pix_reg        <= {word_in, pix_reg[2*WORD_W-1:WORD_W]};
              p_reg          <= p_reg + PW'(8);
              mask_reg       <= mask_next;
              last_reg       <= beats_left_reg == ONE_C;
              beats_left_reg <= beats_left_reg - ONE_C;
              out_valid_reg  <= 1'b1;
            end else begin
              out_valid_reg  <= 1'b0;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign cmd_ready            = state_reg == IDLE;
  assign out_valid            = out_valid_reg;
  assign unaligned_pixels     = pix_reg;
  assign unaligned_valid_mask = mask_reg;
  assign alignment_shift      = shift_reg;
  assign out_last             = last_reg;

endmodule

// File: tb/tb_span_window_builder.sv
// Directed checks of span_window_builder windows, masks, handshakes and reset.
module tb_span_window_builder;

  localparam int X_W = 11;
  localparam logic [71:0] W0 = 72'h0123456789ABCDEF01;
  localparam logic [71:0] W1 = 72'hFEDCBA987654321023;
  localparam logic [71:0] W2 = 72'h5A5A5A5A5A5A5A5A5A;
  localparam logic [71:0] W3 = 72'h13579BDF02468ACE11;
  localparam logic [71:0] ZW = 72'h0;

  logic clk_draw = 1'b0;
  always #5 clk_draw = ~clk_draw;

  logic          rst_draw_n;
  logic          cmd_valid, cmd_ready;
  logic [X_W-1:0] cmd_src_x, cmd_dst_x, cmd_width;
  logic          src_valid, src_ready;
  logic [71:0]   src_pixels;
  logic          out_valid, out_ready;
  logic [143:0]  unaligned_pixels;
  logic [15:0]   unaligned_valid_mask;
  logic [2:0]    alignment_shift;
  logic          out_last;

  logic signed [X_W+1:0] ref_p;
  logic [X_W-1:0]        ref_w;
  logic [15:0]           ref_mask;

  logic [71:0]  src_q[$];
  logic [143:0] cap_pix[$];
  logic [15:0]  cap_mask[$];
  logic [2:0]   cap_shift[$];
  logic         cap_last[$];
  int src_hs;
  int tests_run;
  int tests_failed;

  span_window_builder #(.X_W(X_W)) dut (
    .clk_draw             (clk_draw),
    .rst_draw_n           (rst_draw_n),
    .cmd_valid            (cmd_valid),
    .cmd_ready            (cmd_ready),
    .cmd_src_x            (cmd_src_x),
    .cmd_dst_x            (cmd_dst_x),
    .cmd_width            (cmd_width),
    .src_valid            (src_valid),
    .src_ready            (src_ready),
    .src_pixels           (src_pixels),
    .out_valid            (out_valid),
    .out_ready            (out_ready),
    .unaligned_pixels     (unaligned_pixels),
    .unaligned_valid_mask (unaligned_valid_mask),
    .alignment_shift      (alignment_shift),
    .out_last             (out_last)
  );

  span_mask_gen #(.X_W(X_W)) u_ref_mask (
    .p     (ref_p),
    .width (ref_w),
    .mask  (ref_mask)
  );

  task automatic check(input string tag, input logic [143:0] got, input logic [143:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // One clock: observe handshakes at the negedge, update source stimulus just after the posedge.
  task automatic tick();
    logic popped;
    popped = 1'b0;
    @(negedge clk_draw);
    if (out_valid && out_ready) begin
      cap_pix.push_back(unaligned_pixels);
      cap_mask.push_back(unaligned_valid_mask);
      cap_shift.push_back(alignment_shift);
      cap_last.push_back(out_last);
      $display("[TB] window pix=%h mask=%h shift=%0d last=%0b",
               unaligned_pixels, unaligned_valid_mask, alignment_shift, out_last);
    end
    if (src_valid && src_ready) begin
      src_hs++;
      popped = 1'b1;
    end
    @(posedge clk_draw);
    #1;
    if (popped) void'(src_q.pop_front());
    src_valid  = src_q.size() > 0;
    src_pixels = src_valid ? src_q[0] : '0;
  endtask

  task automatic clear();
    cap_pix.delete();
    cap_mask.delete();
    cap_shift.delete();
    cap_last.delete();
    src_q.delete();
    src_hs     = 0;
    src_valid  = 1'b0;
    src_pixels = '0;
  endtask

  task automatic load(input logic [71:0] w);
    src_q.push_back(w);
    src_valid  = 1'b1;
    src_pixels = src_q[0];
  endtask

  task automatic issue(input string tag, input int sx, input int dx, input int w);
    check({tag, " cmd_ready"}, 144'(cmd_ready), 144'(1));
    $display("[TB] %s cmd src_x=%0d dst_x=%0d width=%0d", tag, sx, dx, w);
    cmd_src_x = X_W'(sx);
    cmd_dst_x = X_W'(dx);
    cmd_width = X_W'(w);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input string tag, input int nbeats);
    int n;
    n = 0;
    while (cap_pix.size() < nbeats && n < 64) begin
      tick();
      n++;
    end
    tick();
    tick();
    check({tag, " beats"}, 144'(cap_pix.size()), 144'(nbeats));
    check({tag, " idle"}, 144'(cmd_ready), 144'(1));
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 32) begin
      tick();
      n++;
    end
    check({tag, " out_valid"}, 144'(out_valid), 144'(1));
  endtask

  task automatic check_beat(input string tag, input int k, input logic [143:0] pix,
                            input logic [15:0] mask, input logic [2:0] shift, input logic last);
    if (k < cap_pix.size()) begin
      check({tag, " pix"},   cap_pix[k],          pix);
      check({tag, " mask"},  144'(cap_mask[k]),   144'(mask));
      check({tag, " shift"}, 144'(cap_shift[k]),  144'(shift));
      check({tag, " last"},  144'(cap_last[k]),   144'(last));
    end else begin
      check({tag, " present"}, 144'(cap_pix.size()), 144'(k + 1));
    end
  endtask

  initial begin
    logic seen_ov;
    tests_run    = 0;
    tests_failed = 0;
    rst_draw_n = 1'b0;
    cmd_valid  = 1'b0;
    cmd_src_x  = '0;
    cmd_dst_x  = '0;
    cmd_width  = '0;
    out_ready  = 1'b0;
    ref_p      = '0;
    ref_w      = '0;
    clear();
    tick();
    tick();
    check("rst out_valid", 144'(out_valid), 144'(0));
    check("rst pix",       unaligned_pixels, 144'(0));
    check("rst mask",      144'(unaligned_valid_mask), 144'(0));
    check("rst shift",     144'(alignment_shift), 144'(0));
    check("rst last",      144'(out_last), 144'(0));
    check("rst cmd_ready", 144'(cmd_ready), 144'(1));
    rst_draw_n = 1'b1;
    tick();

    // Non-phantom span across two source words.
    clear(); load(W0); load(W1); out_ready = 1'b1;
    issue("c1", 3, 1, 8);
    drain("c1", 2);
    check_beat("c1 b0", 0, {W1, W0}, 16'h07F8, 3'd2, 1'b0);
    check_beat("c1 b1", 1, {ZW, W1}, 16'h0007, 3'd2, 1'b1);
    check("c1 src_hs", 144'(src_hs), 144'(2));

    // Phantom span: lo is zeros, single source word.
    clear(); load(W2);
    issue("c2", 1, 3, 4);
    drain("c2", 1);
    check_beat("c2 b0", 0, {W2, ZW}, 16'h1E00, 3'd6, 1'b1);
    check("c2 src_hs", 144'(src_hs), 144'(1));

    // Fully aligned two-word span.
    clear(); load(W0); load(W1);
    issue("c3", 0, 0, 16);
    drain("c3", 2);
    check_beat("c3 b0", 0, {W1, W0}, 16'hFFFF, 3'd0, 1'b0);
    check_beat("c3 b1", 1, {ZW, W1}, 16'h00FF, 3'd0, 1'b1);
    check("c3 src_hs", 144'(src_hs), 144'(2));

    // Case 1 with downstream back-pressure on beat 0.
    clear(); load(W0); load(W1); out_ready = 1'b0;
    issue("c4", 3, 1, 8);
    wait_valid("c4");
    for (int i = 0; i < 3; i++) begin
      tick();
      check("c4 hold valid",     144'(out_valid), 144'(1));
      check("c4 hold pix",       unaligned_pixels, {W1, W0});
      check("c4 hold mask",      144'(unaligned_valid_mask), 144'(16'h07F8));
      check("c4 hold src_ready", 144'(src_ready), 144'(0));
    end
    out_ready = 1'b1;
    drain("c4", 2);
    check_beat("c4 b0", 0, {W1, W0}, 16'h07F8, 3'd2, 1'b0);
    check_beat("c4 b1", 1, {ZW, W1}, 16'h0007, 3'd2, 1'b1);
    check("c4 src_hs", 144'(src_hs), 144'(2));

    // Zero-width command is a no-op, even with source data on offer.
    clear(); load(W2);
    issue("c5", 2, 5, 0);
    seen_ov = out_valid;
    for (int i = 0; i < 4; i++) begin
      tick();
      seen_ov = seen_ov | out_valid;
    end
    check("c5 cmd_ready", 144'(cmd_ready), 144'(1));
    check("c5 out_valid", 144'(seen_ov), 144'(0));
    check("c5 src_hs",    144'(src_hs), 144'(0));

    // Longer span with source data continuing through RUN; masks from the reference generator.
    clear(); load(W0); load(W1); load(W2); load(W3);
    issue("c7", 13, 2, 20);
    drain("c7", 3);
    check("c7 src_hs", 144'(src_hs), 144'(4));
    check_beat("c7 b0", 0, {W1, W0}, 16'hFFE0, 3'd3, 1'b0);
    check_beat("c7 b1", 1, {W2, W1}, 16'hFFFF, 3'd3, 1'b0);
    check_beat("c7 b2", 2, {W3, W2}, 16'h01FF, 3'd3, 1'b1);
    ref_w = X_W'(20);
    for (int k = 0; k < 3; k++) begin
      ref_p = (X_W+2)'(-5 + 8*k);
      #1;
      if (k < cap_mask.size()) check("c7 ref mask", 144'(cap_mask[k]), 144'(ref_mask));
    end

    // Reset mid-span, then a fresh phantom command.
    clear(); load(W0); load(W1); out_ready = 1'b0;
    issue("c6", 0, 0, 16);
    wait_valid("c6");
    check("c6 mid pix", unaligned_pixels, {W1, W0});
    rst_draw_n = 1'b0;
    tick();
    check("c6 rst out_valid", 144'(out_valid), 144'(0));
    check("c6 rst pix",       unaligned_pixels, 144'(0));
    check("c6 rst mask",      144'(unaligned_valid_mask), 144'(0));
    check("c6 rst shift",     144'(alignment_shift), 144'(0));
    check("c6 rst last",      144'(out_last), 144'(0));
    check("c6 rst cmd_ready", 144'(cmd_ready), 144'(1));
    check("c6 rst src_ready", 144'(src_ready), 144'(0));
    rst_draw_n = 1'b1;
    clear(); load(W3); out_ready = 1'b1;
    issue("c6b", 1, 3, 4);
    drain("c6b", 1);
    check_beat("c6b b0", 0, {W3, ZW}, 16'h1E00, 3'd6, 1'b1);
    check("c6b src_hs", 144'(src_hs), 144'(1));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/span_window_builder.md
Name: span_window_builder

Overview:
- Draw-clock stage directly upstream of the shift aligner.
- Takes a per-span command (src_x, dst_x, width) and a stream of 72-bit source words (8 × 9-bit pixels, word-aligned, starting at word src_x>>3).
- Emits one 16-pixel window per destination word: {hi_word, lo_word}, plus a 16-bit span mask and a 3-bit alignment shift.
- The aligner's result, window[shift*9 +: 72], lands on destination word boundaries.

Parameters:
PIXEL_W, 9, bits per pixel (fixed at 9 by the package; a parameter only for readability)
X_W, 11, width of src_x, dst_x and width fields

Ports:
clk_draw  in  1  draw clock
rst_draw_n  in  1  synchronous, active-low reset
cmd_valid  in  1  span command valid
cmd_ready  out  1  high only in IDLE
cmd_src_x  in  X_W  first source pixel index
cmd_dst_x  in  X_W  first destination pixel index
cmd_width  in  X_W  span length in pixels; 0 = no-op
src_valid  in  1  source word valid
src_ready  out  1  source word accepted when src_valid && src_ready
src_pixels  in  72  source word, pixel 0 in bits [8:0]
out_valid  out  1  window valid
out_ready  in  1  downstream accepts window
unaligned_pixels  out  144  {hi_word, lo_word}; lo_word in [71:0]
unaligned_valid_mask  out  16  bit j set iff window pixel j is inside the span
alignment_shift  out  3  window pixel offset for aligned pixel 0
out_last  out  1  final window of the span

Behaviour:
- Reset (rst_draw_n=0 at a clk_draw edge):
  - Outputs: out_valid=0, unaligned_pixels=0, unaligned_valid_mask=0, alignment_shift=0, out_last=0.
  - State returns to IDLE and cmd_ready=1. An in-flight span is abandoned; no further src_ready is asserted for it.
- Derived on command accept (sa=src_x[2:0], da=dst_x[2:0]):
  - phantom = (sa < da).
  - shift = phantom ? 8+sa-da : sa-da, taken mod 8.
  - src_words = (sa+width+7)>>3.
  - beats = (da+width+7)>>3.
  - p0 = phantom ? -(sa+8) : -sa. p is a signed (X_W+2)-bit position of lo_word pixel 0 relative to src_x.
- States:
  - IDLE: cmd_valid && width!=0 → PRIME. width==0 → accept and stay in IDLE, no output.
  - PRIME:
    - Non-phantom: lo=0, then load lo then hi from the source (two words).
    - Phantom: lo=zeros, load hi from the source (one word).
    - Source words beyond src_words load as zeros without asserting src_ready. Then → RUN.
  - RUN:
    - Output register holds a window.
    - On out_valid && out_ready with beats remaining:
      - lo←hi, p+=8.
      - hi←next source word if any remain (stall while !src_valid), else zeros.
    - After the beat with out_last is accepted → IDLE.
- Mask: bit j = (p+j ≥ 0) && (p+j < width), computed for the window being registered.
- out_last=1 exactly on beat index beats-1.
- alignment_shift is constant for the whole span.
- Handshake:
  - Output register updates when !out_valid || out_ready.
  - out_valid holds and data is stable while out_ready=0.
  - src_ready is combinational: asserted only when a word is needed this cycle and the register can update.
  - Throughput is 1 window/cycle with no bubbles between beats when src_valid and out_ready stay high.
- Bounds:
  - width up to 2^X_W−1.
  - Source word count never exceeds src_words.
  - beats may exceed src_words by 1; the trailing hi is zeros.

Decomposition:
- Shared package vdp_pixel_pkg:
  - PIXEL_W=9, PIX_PER_WORD=8.
  - typedef pixel_word_t (72 bits) and pixel_window_t (144 bits).
  - state enum {IDLE, PRIME, RUN}.
- One sub-module, span_mask_gen: purely combinational, (p, width) → 16-bit mask. The bench reuses it as a reference model.

Test Plan:
1. src_x=3, dst_x=1, width=8, words W0,W1 → 2 beats, shift=2.
   - Beat0: {W1,W0}, mask 0x07F8, last=0.
   - Beat1: {0,W1}, mask 0x0007, last=1.
   - Exactly 2 source handshakes.
2. src_x=1, dst_x=3, width=4, word W0 → 1 beat {W0,0}, shift=6, mask 0x1E00, last=1, 1 source handshake.
3. src_x=0, dst_x=0, width=16 → shift=0.
   - Beat0: {W1,W0}, mask 0xFFFF.
   - Beat1: {0,W1}, mask 0x00FF, last=1.
4. Case 1 with out_ready low for 3 cycles after beat0 → beat0 outputs stable for all 3 cycles, src_ready=0 while stalled, sequence unchanged.
5. width=0 command → cmd_ready stays 1, no out_valid, no src_ready.
6. rst_draw_n low for 1 cycle mid-span in case 3 → next cycle out_valid=0, all outputs 0, cmd_ready=1. A new case 2 command then runs correctly.
